// File: rtl/rotary_stick_encoder_if.sv
// Control inputs and encoded position outputs for one rotary-stick player.
interface rotary_stick_encoder_if;
    logic        mode_joy;
    logic        rot_cw;
    logic        rot_ccw;
    logic [3:0]  joy_dir;
    logic [3:0]  pos;
    logic [15:0] TRACKBALL;
    logic        moving;

    modport master (
        output mode_joy, rot_cw, rot_ccw, joy_dir,
        input  pos, TRACKBALL, moving
    );

    modport slave (
        input  mode_joy, rot_cw, rot_ccw, joy_dir,
        output pos, TRACKBALL, moving
    );
endinterface

// File: rtl/rotary_stick_encoder.sv
// 12-position rotary joystick encoder, frame-ticked on VBL rising edge.
// Define ROTARY_GRAY_EN to emit Gray-coded TRACKBALL[3:0] instead of binary.
module rotary_stick_encoder #(
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned SEEK_RATE    = 3,
    parameter int unsigned RESET_POS    = 0
) (
    input  logic                   clk,
    input  logic                   RESETn,
    input  logic                   VBL,
    rotary_stick_encoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, SEEK} state_t;

    function automatic logic [3:0] encode(input logic [3:0] p);
`ifdef ROTARY_GRAY_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    state_t      state;
    logic        vbl_d;
    logic        mode_q;
    logic        dir_cw;
    logic [5:0]  cnt;
    logic [3:0]  pos_q;
    logic [15:0] trackball_q;
    logic        moving_q;

    logic        tick;
    logic        cw_only;
    logic        ccw_only;
    logic        same_dir;
    logic [3:0]  target;
    logic        target_valid;
    logic [4:0]  cw_dist;
    logic        seek_cw;
    logic        adv_cw;
    logic [3:0]  pos_adv;

    always_comb begin
        tick     = VBL & ~vbl_d;
        cw_only  = bus.rot_cw & ~bus.rot_ccw;
        ccw_only = bus.rot_ccw & ~bus.rot_cw;
        same_dir = (cw_only & dir_cw) | (ccw_only & ~dir_cw);

        target       = '0;
        target_valid = 1'b1;
        case (bus.joy_dir)
            4'b1000: target = 4'd0;
            4'b1001: target = 4'd2;
            4'b0001: target = 4'd3;
            4'b0101: target = 4'd5;
            4'b0100: target = 4'd6;
            4'b0110: target = 4'd8;
            4'b0010: target = 4'd9;
            4'b1010: target = 4'd11;
            default: target_valid = 1'b0;
        endcase

        // Clockwise distance modulo 12; a tie at 6 resolves clockwise.
        cw_dist = {1'b0, target} + 5'd12 - {1'b0, pos_q};
        if (cw_dist >= 5'd12)
            cw_dist = cw_dist - 5'd12;
        seek_cw = (cw_dist <= 5'd6);

        adv_cw = bus.mode_joy ? seek_cw : cw_only;
        if (adv_cw)
            pos_adv = (pos_q == 4'd11) ? 4'd0 : pos_q + 4'd1;
        else
            pos_adv = (pos_q == 4'd0) ? 4'd11 : pos_q - 4'd1;
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state       <= IDLE;
            vbl_d       <= 1'b0;
            mode_q      <= 1'b0;
            dir_cw      <= 1'b0;
            cnt         <= '0;
            pos_q       <= 4'(RESET_POS);
            trackball_q <= {12'h000, encode(4'(RESET_POS))};
            moving_q    <= 1'b0;
        end else begin
            vbl_d <= VBL;
            if (tick) begin
                if (bus.mode_joy != mode_q) begin
                    mode_q   <= bus.mode_joy;
                    state    <= IDLE;
                    cnt      <= '0;
                    moving_q <= 1'b0;
                end else if (!bus.mode_joy) begin
                    case (state)
                        IDLE: begin
                            if (cw_only | ccw_only) begin
                                pos_q       <= pos_adv;
                                trackball_q <= {12'h000, encode(pos_adv)};
                                dir_cw      <= cw_only;
                                cnt         <= 6'(REPEAT_DELAY);
                                state       <= HOLD;
                                moving_q    <= 1'b1;
                            end
                        end
                        HOLD, REPEAT: begin
                            if (!same_dir) begin
                                state    <= IDLE;
                                cnt      <= '0;
                                moving_q <= 1'b0;
                            end else if (cnt <= 6'd1) begin
                                pos_q       <= pos_adv;
                                trackball_q <= {12'h000, encode(pos_adv)};
                                cnt         <= 6'(REPEAT_RATE);
                                state       <= REPEAT;
                            end else begin
                                cnt <= cnt - 6'd1;
                            end
                        end
                        default: begin
                            state    <= IDLE;
                            cnt      <= '0;
                            moving_q <= 1'b0;
                        end
                    endcase
                end else begin
                    // A fresh seek steps immediately; an ongoing one keeps its rate count.
                    if (!target_valid || target == pos_q) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        moving_q <= 1'b0;
                    end else if (state != SEEK || cnt <= 6'd1) begin
                        pos_q       <= pos_adv;
                        trackball_q <= {12'h000, encode(pos_adv)};
                        if (pos_adv == target) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            moving_q <= 1'b0;
                        end else begin
                            state    <= SEEK;
                            cnt      <= 6'(SEEK_RATE);
                            moving_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
            end
        end
    end

    assign bus.pos       = pos_q;
    assign bus.TRACKBALL = trackball_q;
    assign bus.moving    = moving_q;

endmodule

// File: tb/tb_rotary_stick_encoder.sv
// Directed self-checking bench for rotary_stick_encoder with default parameters.
module tb_rotary_stick_encoder;

    logic clk = 1'b0;
    logic RESETn = 1'b0;
    logic VBL = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    rotary_stick_encoder_if bus();

    rotary_stick_encoder #(
        .REPEAT_DELAY (12),
        .REPEAT_RATE  (4),
        .SEEK_RATE    (3),
        .RESET_POS    (0)
    ) dut (
        .clk    (clk),
        .RESETn (RESETn),
        .VBL    (VBL),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        @(negedge clk);
        RESETn = 1'b0;
        VBL = 1'b0;
        bus.mode_joy = 1'b0;
        bus.rot_cw = 1'b0;
        bus.rot_ccw = 1'b0;
        bus.joy_dir = 4'b0000;
        repeat (2) @(negedge clk);
        RESETn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        VBL = 1'b1;
        repeat (3) @(negedge clk);
        VBL = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        RESETn = 1'b0;
        bus.mode_joy = 1'b0;
        bus.rot_cw = 1'b0;
        bus.rot_ccw = 1'b0;
        bus.joy_dir = 4'b0000;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.pos !== 4'd0) $display("FAIL reset_pos: got %0d want 0", bus.pos); else n_pass++;
        n_total++;
        if (bus.TRACKBALL !== 16'h0000) $display("FAIL reset_tb: got %h want 0000", bus.TRACKBALL); else n_pass++;
        n_total++;
        if (bus.moving !== 1'b0) $display("FAIL reset_moving: got %b want 0", bus.moving); else n_pass++;
        RESETn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_press();
        apply_reset();
        bus.rot_cw = 1'b1;
        @(negedge clk);
        VBL = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.pos !== 4'd1) $display("FAIL single_pos_edge: got %0d want 1", bus.pos); else n_pass++;
        n_total++;
        if (bus.moving !== 1'b1) $display("FAIL single_moving_hi: got %b want 1", bus.moving); else n_pass++;
        repeat (2) @(negedge clk);
        VBL = 1'b0;
        repeat (3) @(negedge clk);
        bus.rot_cw = 1'b0;
        frame();
        n_total++;
        if (bus.moving !== 1'b0) $display("FAIL single_moving_lo: got %b want 0", bus.moving); else n_pass++;
        n_total++;
        if (bus.pos !== 4'd1) $display("FAIL single_pos_hold: got %0d want 1", bus.pos); else n_pass++;
        // both buttons together from idle: no motion
        bus.rot_cw = 1'b1;
        bus.rot_ccw = 1'b1;
        repeat (3) frame();
        n_total++;
        if (bus.pos !== 4'd1 || bus.moving !== 1'b0)
            $display("FAIL both_buttons: got pos=%0d mv=%b want pos=1 mv=0", bus.pos, bus.moving);
        else n_pass++;
        bus.rot_cw = 1'b0;
        bus.rot_ccw = 1'b0;
    endtask

    task automatic test_hold_repeat();
        logic [3:0] exp_pos;
        apply_reset();
        exp_pos = 4'd0;
        bus.rot_cw = 1'b1;
        for (int f = 0; f < 30; f++) begin
            frame();
            if (f == 0 || (f >= 12 && ((f - 12) % 4) == 0))
                exp_pos = exp_pos + 4'd1;
            n_total++;
            if (bus.pos !== exp_pos)
                $display("FAIL hold_pos f=%0d: got %0d want %0d", f, bus.pos, exp_pos);
            else n_pass++;
        end
        n_total++;
        if (bus.pos !== 4'd6 || bus.moving !== 1'b1)
            $display("FAIL hold_final: got pos=%0d mv=%b want pos=6 mv=1", bus.pos, bus.moving);
        else n_pass++;
        bus.rot_cw = 1'b0;
        frame();
        n_total++;
        if (bus.moving !== 1'b0) $display("FAIL hold_release: got %b want 0", bus.moving); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.rot_ccw = 1'b1;
        frame();
        bus.rot_ccw = 1'b0;
        frame();
        n_total++;
        if (bus.pos !== 4'd11) $display("FAIL wrap_ccw: got %0d want 11", bus.pos); else n_pass++;
        n_total++;
`ifdef ROTARY_GRAY_EN
        if (bus.TRACKBALL !== 16'h000E) $display("FAIL wrap_tb: got %h want 000e", bus.TRACKBALL); else n_pass++;
`else
        if (bus.TRACKBALL !== 16'h000B) $display("FAIL wrap_tb: got %h want 000b", bus.TRACKBALL); else n_pass++;
`endif
        for (int i = 0; i < 12; i++) begin
            bus.rot_cw = 1'b1;
            frame();
            bus.rot_cw = 1'b0;
            frame();
            if (i == 0) begin
                n_total++;
                if (bus.pos !== 4'd0) $display("FAIL wrap_cw_first: got %0d want 0", bus.pos); else n_pass++;
            end
        end
        n_total++;
        if (bus.pos !== 4'd11) $display("FAIL wrap_cw_12: got %0d want 11", bus.pos); else n_pass++;
    endtask

    task automatic test_seek_down();
        logic [3:0] exp_pos;
        apply_reset();
        bus.mode_joy = 1'b1;
        frame();
        n_total++;
        if (bus.pos !== 4'd0 || bus.moving !== 1'b0)
            $display("FAIL seek_mode_tick: got pos=%0d mv=%b want pos=0 mv=0", bus.pos, bus.moving);
        else n_pass++;
        bus.joy_dir = 4'b0100;
        for (int f = 0; f < 16; f++) begin
            frame();
            exp_pos = 4'(f / 3 + 1);
            n_total++;
            if (bus.pos !== exp_pos || bus.moving !== (f != 15))
                $display("FAIL seek_down f=%0d: got pos=%0d mv=%b want pos=%0d mv=%b",
                         f, bus.pos, bus.moving, exp_pos, (f != 15));
            else n_pass++;
        end
        frame();
        n_total++;
        if (bus.pos !== 4'd6) $display("FAIL seek_down_stay: got %0d want 6", bus.pos); else n_pass++;
    endtask

    task automatic test_invalid_then_ul();
        // from 6, R (3) is 3 steps CCW
        bus.joy_dir = 4'b0001;
        repeat (7) frame();
        n_total++;
        if (bus.pos !== 4'd3 || bus.moving !== 1'b0)
            $display("FAIL seek_right: got pos=%0d mv=%b want pos=3 mv=0", bus.pos, bus.moving);
        else n_pass++;
        bus.joy_dir = 4'b1100;
        for (int f = 0; f < 10; f++) begin
            frame();
            n_total++;
            if (bus.pos !== 4'd3 || bus.moving !== 1'b0)
                $display("FAIL invalid_ud f=%0d: got pos=%0d mv=%b want pos=3 mv=0", f, bus.pos, bus.moving);
            else n_pass++;
        end
        bus.joy_dir = 4'b1010;
        for (int f = 0; f < 10; f++) begin
            frame();
            if (f == 0 || f == 3 || f == 6 || f == 9) begin
                n_total++;
                if (bus.pos !== ((f == 0) ? 4'd2 : (f == 3) ? 4'd1 : (f == 6) ? 4'd0 : 4'd11))
                    $display("FAIL seek_ul f=%0d: got %0d", f, bus.pos);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.moving !== 1'b0) $display("FAIL seek_ul_stop: got %b want 0", bus.moving); else n_pass++;
    endtask

    task automatic test_mode_change();
        apply_reset();
        bus.rot_cw = 1'b1;
        repeat (3) frame();
        bus.mode_joy = 1'b1;
        frame();
        n_total++;
        if (bus.pos !== 4'd1 || bus.moving !== 1'b0)
            $display("FAIL mode_change: got pos=%0d mv=%b want pos=1 mv=0", bus.pos, bus.moving);
        else n_pass++;
        frame();
        n_total++;
        if (bus.pos !== 4'd1) $display("FAIL buttons_ignored_stick: got %0d want 1", bus.pos); else n_pass++;
        bus.rot_cw = 1'b0;
        bus.mode_joy = 1'b0;
        frame();
    endtask

    task automatic test_encoding();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            bus.rot_cw = 1'b1;
            frame();
            bus.rot_cw = 1'b0;
            frame();
        end
        n_total++;
        if (bus.pos !== 4'd7) $display("FAIL enc_pos: got %0d want 7", bus.pos); else n_pass++;
        n_total++;
`ifdef ROTARY_GRAY_EN
        if (bus.TRACKBALL !== 16'h0004) $display("FAIL enc_tb: got %h want 0004", bus.TRACKBALL); else n_pass++;
`else
        if (bus.TRACKBALL !== 16'h0007) $display("FAIL enc_tb: got %h want 0007", bus.TRACKBALL); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.rot_cw = 1'b1;
        repeat (14) frame();
        n_total++;
        if (bus.pos !== 4'd2 || bus.moving !== 1'b1)
            $display("FAIL pre_reset: got pos=%0d mv=%b want pos=2 mv=1", bus.pos, bus.moving);
        else n_pass++;
        #2;
        RESETn = 1'b0;
        #1;
        n_total++;
        if (bus.pos !== 4'd0 || bus.moving !== 1'b0 || bus.TRACKBALL !== 16'h0000)
            $display("FAIL async_reset: got pos=%0d mv=%b tb=%h want pos=0 mv=0 tb=0000",
                     bus.pos, bus.moving, bus.TRACKBALL);
        else n_pass++;
        bus.rot_cw = 1'b0;
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_wrap();
        test_seek_down();
        test_invalid_then_ul();
        test_mode_change();
        test_encoding();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
